// File: rtl/trap_sequencer.sv
// Machine-mode trap sequencer: arbitrates exceptions, external interrupt and mret.
// It captures the trap CSRs and drives the fetch redirect handshake. Build option: RV_TRAP_VECTORED_EN.
module trap_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            resetb_i,
  input  logic            clk_en_i,
  input  logic            excp_ferr_i,
  input  logic            excp_uerr_i,
  input  logic            excp_maif_i,
  input  logic            excp_mala_i,
  input  logic            excp_masa_i,
  input  logic            excp_ilgl_i,
  input  logic [XLEN-1:0] excp_pc_i,
  input  logic [XLEN-1:0] excp_tval_i,
  input  logic            irq_ext_i,
  input  logic            mret_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic            csr_wr_i,
  input  logic [11:0]     csr_wr_addr_i,
  input  logic [XLEN-1:0] csr_wr_data_i,
  input  logic            jump_ack_i,
  output logic [XLEN-1:0] mepc_o,
  output logic [XLEN-1:0] mcause_o,
  output logic [XLEN-1:0] mtval_o,
  output logic            mstatus_mie_o,
  output logic            mstatus_mpie_o,
  output logic            jump_o,
  output logic [XLEN-1:0] jump_addr_o,
  output logic            busy_o
);

  localparam logic [11:0]     ADDR_MSTATUS = 12'h300;
  localparam logic [11:0]     ADDR_MEPC    = 12'h341;
  localparam logic [11:0]     ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0]     ADDR_MTVAL   = 12'h343;
  localparam logic [XLEN-1:0] WORD_MASK    = {{(XLEN-2){1'b1}}, 2'b00};
  localparam logic [XLEN-1:0] IRQ_CAUSE    = {1'b1, {(XLEN-5){1'b0}}, 4'd11};

  typedef enum logic [1:0] {IDLE, SAVE, JUMP} state_e;

  typedef struct packed {
    logic            ret;
    logic            irq;
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] tval;
  } trap_req_t;

  state_e    state_q, state_d;
  trap_req_t req_q, req_d;
  logic      excp_any, irq_take;
  logic [XLEN-1:0] tvec_base, trap_tgt;

  // Priority encode; tval only survives for the address-carrying exceptions.
  always_comb begin
    excp_any  = excp_ferr_i | excp_uerr_i | excp_maif_i | excp_mala_i | excp_masa_i | excp_ilgl_i;
    irq_take  = irq_ext_i & mstatus_mie_o;
    req_d     = '0;
    req_d.ret = ~excp_any & ~irq_take;
    req_d.irq = ~excp_any & irq_take;
    req_d.pc  = excp_pc_i & WORD_MASK;
    if (excp_ferr_i)      req_d.cause = XLEN'(1);
    else if (excp_uerr_i) req_d.cause = XLEN'(2);
    else if (excp_maif_i) begin req_d.cause = XLEN'(0); req_d.tval = excp_tval_i; end
    else if (excp_mala_i) begin req_d.cause = XLEN'(4); req_d.tval = excp_tval_i; end
    else if (excp_masa_i) begin req_d.cause = XLEN'(6); req_d.tval = excp_tval_i; end
    else if (excp_ilgl_i) req_d.cause = XLEN'(2);
    else if (irq_take)    req_d.cause = IRQ_CAUSE;
  end

  always_comb begin
    tvec_base = mtvec_i & WORD_MASK;
`ifdef RV_TRAP_VECTORED_EN
    trap_tgt  = (req_q.irq && mtvec_i[1:0] == 2'b01) ? tvec_base + XLEN'(44) : tvec_base;
`else
    trap_tgt  = tvec_base;
`endif
  end

`ifndef RV_TRAP_VECTORED_EN
  logic unused_vec;
  assign unused_vec = ^{mtvec_i[1:0], req_q.irq};
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (excp_any || irq_take || mret_i) state_d = SAVE;
      SAVE:    state_d = JUMP;
      JUMP:    if (jump_ack_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign jump_o = (state_q == JUMP);
  assign busy_o = (state_q != IDLE);

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q <= IDLE;
      req_q   <= '0;
    end else if (clk_en_i) begin
      state_q <= state_d;
      if (state_q == IDLE && state_d == SAVE) req_q <= req_d;
    end
  end

  // Software writes first so a same-cycle SAVE update overrides them.
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      mepc_o         <= '0;
      mcause_o       <= '0;
      mtval_o        <= '0;
      mstatus_mie_o  <= 1'b0;
      mstatus_mpie_o <= 1'b0;
      jump_addr_o    <= '0;
    end else if (clk_en_i) begin
      if (csr_wr_i) begin
        case (csr_wr_addr_i)
          ADDR_MEPC:    mepc_o   <= csr_wr_data_i & WORD_MASK;
          ADDR_MCAUSE:  mcause_o <= csr_wr_data_i;
          ADDR_MTVAL:   mtval_o  <= csr_wr_data_i;
          ADDR_MSTATUS: begin
            mstatus_mie_o  <= csr_wr_data_i[3];
            mstatus_mpie_o <= csr_wr_data_i[7];
          end
          default: ;
        endcase
      end
      if (state_q == SAVE) begin
        if (req_q.ret) begin
          mstatus_mie_o  <= mstatus_mpie_o;
          mstatus_mpie_o <= 1'b1;
          jump_addr_o    <= mepc_o;
        end else begin
          mepc_o         <= req_q.pc;
          mcause_o       <= req_q.cause;
          mtval_o        <= req_q.tval;
          mstatus_mpie_o <= mstatus_mie_o;
          mstatus_mie_o  <= 1'b0;
          jump_addr_o    <= trap_tgt;
        end
      end
    end
  end

endmodule

// File: doc/trap_sequencer.md
# trap_sequencer

Machine-mode trap controller for the rv32i hart. It arbitrates exception and external-interrupt requests and sequences trap entry. Trap entry captures mepc, mcause and mtval, updates the mstatus interrupt-enable stack, and issues a redirect to fetch under a request/acknowledge handshake. It also sequences `mret` returns. It sits beside the CSR file: it owns mepc/mcause/mtval/MIE/MPIE, and the CSR file forwards software writes to it.

## Interface
- `XLEN`, 32: data/address width.
- `clk_i`  in  1: clock.
- `resetb_i`  in  1: reset, asynchronous, active-low.
- `clk_en_i`  in  1: global clock enable. When low, all state holds.
- `excp_ferr_i`, `excp_uerr_i`, `excp_maif_i`, `excp_mala_i`, `excp_masa_i`, `excp_ilgl_i`  in  1 each: exception flags from the retiring instruction.
- `excp_pc_i`  in  XLEN: PC of the faulting or interrupted instruction.
- `excp_tval_i`  in  XLEN: faulting address for misaligned exceptions.
- `irq_ext_i`  in  1: level-sensitive machine external interrupt.
- `mret_i`  in  1: retiring `mret`.
- `mtvec_i`  in  XLEN: current mtvec value from the CSR file.
- `csr_wr_i`  in  1: software CSR write strobe.
- `csr_wr_addr_i`  in  12: CSR write address.
- `csr_wr_data_i`  in  XLEN: CSR write data, already read-modify-write resolved.
- `jump_ack_i`  in  1: fetch accepts the redirect.
- `mepc_o`, `mcause_o`, `mtval_o`  out  XLEN: trap CSR values, read by the CSR file.
- `mstatus_mie_o`, `mstatus_mpie_o`  out  1: interrupt enable bits.
- `jump_o`  out  1: redirect request.
- `jump_addr_o`  out  XLEN: redirect target.
- `busy_o`  out  1: high in SAVE and JUMP. The pipeline stalls retirement while it is high.

## Operation
- States:
  - IDLE (reset state).
  - SAVE: one cycle.
  - JUMP: holds until `jump_ack_i`.
- Transitions, evaluated only in IDLE with `clk_en_i` high:
  - Any exception flag → SAVE, trap entry.
  - Otherwise `irq_ext_i & mstatus_mie_o` → SAVE, trap entry.
  - Otherwise `mret_i` → SAVE, return.
  - Otherwise stay in IDLE.
- Exception priority and mcause:
  - `ferr` = 1.
  - `uerr` = 2.
  - `maif` = 0.
  - `mala` = 4.
  - `masa` = 6.
  - `ilgl` = 2.
  - External interrupt = 0x8000000B.
- Any exception beats an interrupt; any trap beats `mret`.
- SAVE for trap entry:
  - mepc ← `excp_pc_i & ~3`.
  - mcause ← encoded cause.
  - mtval ← `excp_tval_i` for maif/mala/masa, else 0.
  - MPIE ← MIE; MIE ← 0.
  - `jump_addr_o` ← trap target.
- SAVE for return:
  - MIE ← MPIE; MPIE ← 1.
  - `jump_addr_o` ← mepc.
- Cause, pc and tval are latched on the IDLE→SAVE edge. Inputs that change later are ignored.
- JUMP:
  - `jump_o` = 1, `jump_addr_o` stable.
  - On `jump_ack_i` (with `clk_en_i`) → IDLE; `jump_o` drops the next cycle.
- Software writes apply in any state. Addresses:
  - 0x341 writes mepc, with bits [1:0] forced to 0.
  - 0x342 writes mcause.
  - 0x343 writes mtval.
  - 0x300 writes bit 3 → MIE and bit 7 → MPIE.
  - Other addresses are ignored.
- If a software write and the SAVE update target the same register in the same cycle, the SAVE update wins.
- Events presented while busy are not captured. Upstream holds them because `busy_o` stalls retirement.

## Timing
- Reset values:
  - mepc, mcause, mtval: 0.
  - MIE, MPIE: 0.
  - `jump_o`: 0.
  - `jump_addr_o`: 0.
  - `busy_o`: 0.
  - State: IDLE.
- Event sampled at edge N → SAVE during cycle N+1. CSR outputs are updated at edge N+1.
- `jump_o` is high from cycle N+2 onward. Minimum event-to-IDLE latency is 3 edges when ack arrives in the first JUMP cycle.
- `busy_o` is combinational from state.
- Reset asserted mid-sequence: return immediately to IDLE with all outputs at reset values. The redirect is abandoned.
- `clk_en_i` low: no state or register advances. An ack presented while `clk_en_i` is low is not taken.

## Configuration
- `RV_TRAP_VECTORED_EN`:
  - Defined:
    - If `mtvec_i[1:0]` = 01, the interrupt target is `(mtvec_i & ~3) + 4*11`.
    - Exceptions always go to `mtvec_i & ~3`.
  - Undefined:
    - `mtvec_i[1:0]` is ignored.
    - All traps go to `mtvec_i & ~3`.

## Test plan
- Misaligned load: `excp_mala_i`=1, pc=0x100, tval=0x203, mtvec=0x80, MIE=1. Required:
  - mcause=4, mepc=0x100, mtval=0x203, MIE=0, MPIE=1.
  - `jump_addr_o`=0x80.
  - `jump_o` held through 3 stalled-ack cycles, then dropped after ack.
- Priority: `excp_ferr_i`, `excp_ilgl_i` and `irq_ext_i` together. Required: mcause=1, mtval=0.
- Interrupt, vectored: MIE=1, `irq_ext_i`=1, mtvec=0x201. Required:
  - mcause=0x8000000B.
  - With `RV_TRAP_VECTORED_EN` defined, target 0x22C; without it, target 0x200.
  - With MIE=0 the same stimulus produces no trap.
- mret: after the interrupt above, `mret_i`=1. Required: MIE=1, MPIE=1, `jump_addr_o`=mepc.
- Software/SAVE collision: CSR write mepc=0x444 in the same cycle as SAVE of pc=0x100. Required: mepc=0x100. A write in IDLE gives mepc=0x444; a write of 0x447 gives 0x444.
- Reset in JUMP: `resetb_i` low while `jump_o`=1. Required: `jump_o`=0, all CSRs 0, `busy_o`=0 asynchronously. After release, the block accepts a new exception.
